// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver, LSB first, mid-bit sampling.
// Bit timing comes from a clk-cycle counter; no divided clock.
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 5212,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] TOP  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t               state, state_n;
  logic                 rx_m, rx_s;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] dout_n;
  logic                 valid_n, err_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      data_out   <= dout_n;
      data_valid <= valid_n;
      frame_err  <= err_n;
      busy       <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = (cnt == LAST) ? '0 : cnt + CW'(1);
    idx_n   = idx;
    shreg_n = shreg;
    dout_n  = data_out;
    valid_n = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          idx_n   = idx + IW'(1);
          if (idx == TOP) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          if (rx_s) begin
            dout_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = BRK;
          end
        end
      end
      BRK: begin
        // a held-low line must go high before a new start is accepted
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1 at 16 clk per bit.
// Frames are driven cycle by cycle; received bytes are scored against a queue model.
module tb_uart_rx_8n1;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  logic [7:0] got[$];
  int         nvalid = 0;
  int         nerr   = 0;
  int         vcyc   = 0;
  bit         both   = 1'b0;

  always @(negedge clk) begin
    if (data_valid) begin
      got.push_back(data_out);
      nvalid <= nvalid + 1;
      vcyc   <= cyc;
    end
    if (frame_err) nerr <= nerr + 1;
    if (data_valid && frame_err) both <= 1'b1;
  end

  logic [7:0] exp_q[$];
  int         exp_err  = 0;
  logic [7:0] exp_last = 8'h00;

  function automatic void model(input logic [7:0] b, input bit stop);
    if (stop) begin
      exp_q.push_back(b);
      exp_last = b;
    end else begin
      exp_err++;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] popg();
    if (got.size() == 0) return {32{1'bx}};
    return {24'h0, got.pop_front()};
  endfunction

  task automatic drain(input string tag);
    chk({tag, "_n"}, got.size(), exp_q.size());
    while (exp_q.size() > 0) chk(tag, popg(), {24'h0, exp_q.pop_front()});
    got.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 rx = 1'b1;
    end
  endtask

  int st;
  int trans[$];

  // rst_at >= 0 aborts the frame with a one-cycle reset at that bit-time offset
  task automatic send(input logic [7:0] b, input bit stop, input bit jit,
                      input int rst_at);
    int   offs[10];
    logic lvl[10];
    logic prev;
    lvl[0] = 1'b0;
    for (int i = 0; i < 8; i++) lvl[i+1] = b[i];
    lvl[9] = stop;
    offs[0] = 0;
    for (int j = 1; j < 10; j++)
      offs[j] = jit ? int'($urandom_range(6)) - 3 : 0;
    trans.delete();
    prev = 1'b1;
    for (int c = 0; c < 10 * CPB; c++) begin
      int   k;
      logic v;
      @(posedge clk);
      #1;
      if (c == 0) st = cyc;
      if (c == rst_at) begin
        rst_n = 1'b0;
        rx    = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      k = 0;
      for (int j = 1; j < 10; j++) if (c >= j * CPB + offs[j]) k = j;
      v = lvl[k];
      if (v !== prev) trans.push_back(c);
      prev = v;
      rx   = v;
    end
  endtask

  initial begin
    logic [7:0] b;
    bit         s;
    int         md, d, v0, e0;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_dout", data_out, 0);
    chk("rst_flags", {data_valid, frame_err, busy}, 0);
    idle(5);

    // good frame; strobe lands 2 sync cycles + 9.5 bits + 1 register after the edge
    send(8'hA5, 1'b1, 1'b0, -1);
    model(8'hA5, 1'b1);
    idle(20);
    drain("a5_data");
    chk("a5_valid_cnt", nvalid, 1);
    chk("a5_err", nerr, exp_err);
    chk("a5_latency", vcyc - st, 2 + (DB + 1) * CPB + CPB / 2 + 1);
    chk("a5_dout", data_out, exp_last);
    chk("a5_busy", busy, 0);

    // 4-clk glitch
    v0 = nvalid;
    e0 = nerr;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
    @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_strobes", {nvalid - v0, nerr - e0}, 0);
    idle(10);

    // low stop bit, then line held low
    v0 = nvalid;
    send(8'h3C, 1'b0, 1'b0, -1);
    model(8'h3C, 1'b0);
    repeat (40) begin
      @(posedge clk);
      #1 rx = 1'b0;
    end
    chk("ferr_cnt", nerr, exp_err);
    chk("ferr_novalid", nvalid - v0, 0);
    chk("ferr_dout", data_out, exp_last);
    chk("ferr_busy_hold", busy, 1);
    idle(30);
    chk("ferr_cnt_after", nerr, exp_err);
    chk("ferr_busy_lo", busy, 0);

    // back-to-back frames, no idle gap
    send(8'h00, 1'b1, 1'b0, -1);
    model(8'h00, 1'b1);
    send(8'hFF, 1'b1, 1'b0, -1);
    model(8'hFF, 1'b1);
    idle(20);
    drain("b2b_data");
    chk("b2b_err", nerr, exp_err);
    chk("b2b_dout", data_out, exp_last);

    // reset in the middle of data bit 3
    send(8'h55, 1'b1, 1'b0, 4 * CPB + CPB / 2);
    exp_last = 8'h00;
    @(negedge clk);
    chk("mid_rst_dout", data_out, exp_last);
    chk("mid_rst_flags", {data_valid, frame_err, busy}, 0);
    idle(20);
    send(8'h81, 1'b1, 1'b0, -1);
    model(8'h81, 1'b1);
    idle(20);
    drain("post_rst_data");
    chk("post_rst_dout", data_out, exp_last);

    // edge jitter of +-3 clk
    send(8'h6E, 1'b1, 1'b1, -1);
    model(8'h6E, 1'b1);
    idle(20);
    drain("jit_data");
    md = 1000;
    foreach (trans[i]) begin
      if (trans[i] > 0) begin
        for (int k = 0; k < 10; k++) begin
          d = trans[i] - (k * CPB + CPB / 2);
          if (d < 0) d = -d;
          if (d < md) md = d;
        end
      end
    end
    chk("jit_margin", md >= 4, 1);

    // random bytes with occasional bad stop bits
    repeat (8) begin
      b = 8'($urandom);
      s = ($urandom_range(3) != 0);
      send(b, s, 1'b0, -1);
      model(b, s);
      idle(int'($urandom_range(20, 4)));
    end
    idle(10);
    drain("rand_data");
    chk("rand_err", nerr, exp_err);
    chk("final_dout", data_out, exp_last);
    chk("no_overlap", both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
